// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the elastic inter-stage pipeline registers.
//   - Stage bundle field widths and the derived IF/ID payload width.
//   - Occupancy state encoding of the skid-buffered stage.
//   - pack_fd(): builds the IF/ID bundle {JAL, target, pred, PC+4, instr},
//     MSB to LSB.
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int INSTR_W   = 32;
  localparam int PC_W      = 32;
  localparam int PRED_W    = 6;
  localparam int TGT_W     = 32;
  localparam int FD_DATA_W = 1 + TGT_W + PRED_W + PC_W + INSTR_W;

  // Encoding equals the number of held entries, so it doubles as occupancy.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_e;

  function automatic logic [FD_DATA_W-1:0] pack_fd(
    input logic              jal,
    input logic [TGT_W-1:0]   target,
    input logic [PRED_W-1:0]  pred,
    input logic [PC_W-1:0]    pc4,
    input logic [INSTR_W-1:0] instr
  );
    return {jal, target, pred, pc4, instr};
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// -----------------------------------------------------------------------------
// pipe_sat_counter
// Saturating up-counter with synchronous active-high reset.
//   CLK   in   clock, rising edge
//   RST   in   synchronous reset, clears count
//   inc   in   increment request; ignored once count is all-ones
//   count out  current value
// -----------------------------------------------------------------------------
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic
// Inter-stage pipeline register with valid/ready handshake and flush.
//
// Handshake: a beat moves when valid and ready are both high at a rising
// edge. in_valid/in_data must be held by the producer until accepted;
// out_valid/out_data are held stable by this stage while out_ready is low.
// flush kills every held entry and this cycle's input; RST beats flush.
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   flush                 synchronous kill of held entries and current input
//   in_valid/in_ready     upstream handshake (in_ready registered when SKID=1)
//   in_data   [DATA_W]    upstream payload
//   out_valid/out_ready   downstream handshake
//   out_data  [DATA_W]    payload, straight from a register
//   occupancy [2]         entries held; equals the FSM state when SKID=1
// Optional (macro PIPE_STAGE_PERF_EN):
//   stall_cnt [32]        cycles with out_valid & !out_ready (saturating)
//   flush_cnt [16]        flushes that killed at least one entry (saturating)
// -----------------------------------------------------------------------------
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W   = FD_DATA_W,
  parameter int SKID     = 1,
  parameter int CLR_ZERO = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  generate
    if (SKID == 0) begin : g_single
      logic              valid_q;
      logic [DATA_W-1:0] data_q;
      logic              xfer_in;
      logic              xfer_out;

      // Combinational ready: a slot frees up in the same cycle it drains.
      assign in_ready  = out_ready | ~valid_q;
      assign xfer_in   = in_valid & in_ready & ~flush;
      assign xfer_out  = valid_q & out_ready;
      assign out_valid = valid_q;
      assign out_data  = data_q;
      assign occupancy = {1'b0, valid_q};

      always_ff @(posedge CLK) begin
        if (RST) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else if (flush) begin
          valid_q <= 1'b0;
          if (CLR_ZERO != 0) data_q <= '0;
        end else if (xfer_in) begin
          valid_q <= 1'b1;
          data_q  <= in_data;
        end else if (xfer_out) begin
          valid_q <= 1'b0;
        end
      end
    end else begin : g_skid
      occ_state_e        state_q, state_d;
      logic [DATA_W-1:0] main_q, main_d;
      logic [DATA_W-1:0] skid_q, skid_d;
      logic              xfer_in;
      logic              xfer_out;

      // Ready depends only on the state register: no downstream-to-upstream
      // combinational path.
      assign in_ready  = (state_q != ST_TWO);
      assign out_valid = (state_q != ST_EMPTY);
      assign out_data  = main_q;
      assign occupancy = state_q;
      assign xfer_in   = in_valid & in_ready & ~flush;
      assign xfer_out  = out_valid & out_ready;

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
          state_d = ST_EMPTY;
          if (CLR_ZERO != 0) begin
            main_d = '0;
            skid_d = '0;
          end
        end else begin
          unique case (state_q)
            ST_EMPTY: begin
              if (xfer_in) begin
                state_d = ST_ONE;
                main_d  = in_data;
              end
            end
            ST_ONE: begin
              if (xfer_in && xfer_out) begin
                main_d = in_data;
              end else if (xfer_in) begin
                // Main is stalled; park the newcomer behind it.
                state_d = ST_TWO;
                skid_d  = in_data;
              end else if (xfer_out) begin
                state_d = ST_EMPTY;
              end
            end
            ST_TWO: begin
              if (xfer_out) begin
                state_d = ST_ONE;
                main_d  = skid_q;
              end
            end
            default: state_d = ST_EMPTY;
          endcase
        end
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          state_q <= ST_EMPTY;
          main_q  <= '0;
          skid_q  <= '0;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
        end
      end

      // Skid valid without main valid has no encoding; catch corruption.
      a_legal_state: assert property (@(posedge CLK) disable iff (RST)
        state_q inside {ST_EMPTY, ST_ONE, ST_TWO});
    end
  endgenerate

  // A stalled live entry must stay put until consumed or flushed.
  a_stall_stable: assert property (@(posedge CLK) disable iff (RST)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter #(.W(32)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.W(16)) u_flush_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (flush & (occupancy != 2'd0)),
    .count (flush_cnt)
  );
`endif

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Generalised inter-stage pipeline register (IF/ID, ID/EX, ...) with a valid/ready handshake replacing the bare stall/clear pair.
- Payload width is parametrised, so one block carries any stage bundle (instruction, PC+4, predictor state, predicted target, flags).
- Optional 2-entry skid buffer registers in_ready, breaking the combinational stall path from downstream to upstream.
- Synchronous flush kills in-flight entries on branch mispredict / exception.

Parameters:
- DATA_W, 103: payload width in bits. Default covers instr 32 + PC+4 32 + pred 6 + target 32 + JAL 1.
- SKID, 1: 0 = single register, in_ready combinational; 1 = main + skid entry, in_ready registered.
- CLR_ZERO, 1: 1 = payload registers forced to 0 on reset/flush (zero instr = NOP); 0 = payload retained, only valid cleared.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- flush  in  1  synchronous kill of all held entries and of this cycle's input
- in_valid  in  1  upstream presents payload
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  out_data holds a live entry
- out_ready  in  1  downstream consumes this cycle (0 = stall)
- out_data  out  DATA_W  payload to next stage
- occupancy  out  2  entries held (0..1 when SKID=0, 0..2 when SKID=1)

Behaviour:
- Transfer in: in_valid & in_ready & !flush. Transfer out: out_valid & out_ready.
- Reset (RST=1 at edge): out_valid=0, occupancy=0, out_data=0, skid entry=0 and invalid, in_ready=1 from the next cycle. Reset has priority over flush and all traffic.
- Flush (RST=0, flush=1 at edge):
  - All entries invalidated; occupancy goes to 0.
  - Payloads zeroed if CLR_ZERO=1.
  - This cycle's in_data is dropped even if in_valid=1 and in_ready=1.
  - Flush takes effect regardless of out_ready.
  - Next cycle: in_ready=1.
- SKID=0:
  - in_ready = out_ready | !out_valid (combinational).
  - Load on transfer in; clear valid on transfer out with no transfer in.
  - Simultaneous in/out moves the new payload through. Latency 1 cycle.
- SKID=1 states:
  - EMPTY (occ 0), ONE (occ 1, main valid), TWO (occ 2, main + skid valid).
  - in_ready = (state != TWO), registered.
- SKID=1 transitions:
  - EMPTY: transfer in -> ONE; main <= in_data.
  - ONE: in & out -> ONE, main <= in_data; in only -> TWO, skid <= in_data; out only -> EMPTY.
  - TWO: out -> ONE, main <= skid (no input accepted, in_ready=0); else hold.
- SKID=1 latency and ordering: in -> out latency is 1 cycle when EMPTY. Order is strictly FIFO; no payload is duplicated or lost without a flush.
- Stall: out_ready=0 holds out_data and out_valid stable. This is required, and is an AXI-style stability assertion target.
- out_data is a direct register output, with no combinational path from in_data.
- Illegal states (skid valid while main invalid) are unreachable and are asserted against in simulation.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN. When defined, adds outputs:
  - stall_cnt (32 bit): increments each cycle out_valid & !out_ready.
  - flush_cnt (16 bit): increments each cycle flush=1 with occupancy != 0.
- Both counters saturate at all-ones, reset to 0 on RST and are unaffected by flush.
- Undefined: ports and counters are absent; area and timing are identical to the base block.

Decomposition:
- Shared package pipe_pkg:
  - Stage bundle widths: INSTR_W=32, PC_W=32, PRED_W=6, TGT_W=32.
  - FD_DATA_W derived from those widths.
  - Occupancy state encoding: ST_EMPTY=0, ST_ONE=1, ST_TWO=2.
  - Packing order for the IF/ID bundle: {JAL, target, pred, PC+4, instr}, MSB to LSB.
- One natural sub-module: pipe_sat_counter (parametrised width, saturating increment, sync reset). It is instantiated twice under PIPE_STAGE_PERF_EN.

Test Plan:
- Reset: RST=1 for 2 cycles with in_valid=1, in_data=0x5A... -> out_valid=0, out_data=0, occupancy=0; in_ready=1 the cycle after RST falls.
- Streaming: SKID=1, out_ready=1, in_data=1,2,3 back-to-back -> out_data=1,2,3 on consecutive cycles one cycle later; occupancy stays 1; in_ready stays 1.
- Stall and skid: 1,2,3 offered, out_ready=0 from cycle 1:
  - 1 in main, 2 in skid, occupancy=2, in_ready=0; 3 held upstream.
  - out_ready=1 -> outputs 1,2,3 in order, none lost.
- Flush priority:
  - In state TWO with out_ready=0, assert flush with in_valid=1, in_data=0xDEAD -> next cycle out_valid=0, occupancy=0, out_data=0 (CLR_ZERO=1).
  - 0xDEAD is never output.
- Reset over flush: RST=1 and flush=1 together with occupancy=2 -> reset values; with PIPE_STAGE_PERF_EN, flush_cnt=0.
- Perf counters (PIPE_STAGE_PERF_EN): 5 stall cycles then 1 flush with occupancy 1 -> stall_cnt=5, flush_cnt=1; preload near saturation -> stall_cnt holds 0xFFFFFFFF.
